// File: rtl/sid_bus_ctrl_pkg.sv
// sid_bus_ctrl shared types: FSM states, chip select, register map.
// Helpers for select decode, one-hot chip strobes, readable-register test.
package sid_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LOW,
    HIGH,
    READ,
    HOLD
  } bus_ctrl_state_t;

  typedef enum logic [1:0] {
    NONE,
    CHIP0,
    CHIP1
  } chip_sel_t;

  localparam logic [4:0] REG_POTX = 5'h19;
  localparam logic [4:0] REG_POTY = 5'h1A;
  localparam logic [4:0] REG_OSC3 = 5'h1B;
  localparam logic [4:0] REG_ENV3 = 5'h1C;

  // /CS wins over /IO1 when both are low
  function automatic chip_sel_t decode_sel(
    input logic [1:0] cs_n
  );
    chip_sel_t s;
    if (!cs_n[0])      s = CHIP0;
    else if (!cs_n[1]) s = CHIP1;
    else               s = NONE;
    return s;
  endfunction

  function automatic logic [1:0] chip_oh(
    input chip_sel_t s
  );
    logic [1:0] oh;
    unique case (s)
      CHIP0:   oh = 2'b01;
      CHIP1:   oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

  function automatic logic is_readable(
    input logic [4:0] a
  );
    return (a >= REG_POTX) && (a <= REG_ENV3);
  endfunction

endpackage

// File: rtl/sid_bus_ctrl_if.sv
// Pad-side bus bundle for sid_bus_ctrl.
// master: pads + cores drive inputs; slave: the controller.
interface sid_bus_ctrl_if;
  logic        phi2;
  logic        r_w_n;
  logic [1:0]  cs_n;
  logic [4:0]  addr;
  logic [7:0]  data_i;
  logic [1:0]  we;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_req;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  data_o;
  logic        drive;

  modport master (
    output phi2, r_w_n, cs_n, addr,
    output data_i, rd_data,
    input  we, wr_addr, wr_data,
    input  rd_req, rd_addr,
    input  data_o, drive
  );

  modport slave (
    input  phi2, r_w_n, cs_n, addr,
    input  data_i, rd_data,
    output we, wr_addr, wr_data,
    output rd_req, rd_addr,
    output data_o, drive
  );
endinterface

// File: rtl/sid_bus_ctrl_decay.sv
// Per-chip decaying data-bus latch: value + TTL in phi2 cycles.
// Ports: clk, rst, load/load_data (reload), tick (valid phi2 fall), value.
module sid_bus_decay #(
  parameter int DECAY_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tick,
  output logic [7:0] value
);
  localparam int TW = $clog2(DECAY_CYCLES + 1);
  localparam logic [TW-1:0] TTL_INIT = TW'(DECAY_CYCLES);

  logic [TW-1:0] ttl;

  // load beats tick; value clears on the tick that empties the TTL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ttl   <= '0;
      value <= '0;
    end else if (load) begin
      ttl   <= TTL_INIT;
      value <= load_data;
    end else if (tick && ttl != '0) begin
      ttl <= ttl - 1'b1;
      if (ttl == TW'(1)) value <= '0;
    end
  end
endmodule

// File: rtl/sid_bus_ctrl.sv
// SID bus sequencer: phi2 phase FSM, write strobes, read scheduling.
// Ports: clk, rst, bus (slave modport of sid_bus_ctrl_if).
module sid_bus_ctrl
  import sid_bus_ctrl_pkg::*;
#(
  parameter int DECAY_CYCLES = 8192,
  parameter int MIN_HIGH     = 4,
  parameter int RD_LAT       = 1
) (
  input logic           clk,
  input logic           rst,
  sid_bus_ctrl_if.slave bus
);
  localparam int HW = $clog2(MIN_HIGH + 1);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [HW-1:0] H_MAX = HW'(MIN_HIGH);
  localparam logic [LW-1:0] L_MAX = LW'(RD_LAT);

  bus_ctrl_state_t state;
  logic            phi2_q;
  logic [HW-1:0]   hcnt;
  logic [LW-1:0]   lcnt;
  chip_sel_t       rsel;
  logic [1:0]      we_q;
  logic [1:0]      rd_req_q;
  logic [4:0]      wr_addr_q;
  logic [4:0]      rd_addr_q;
  logic [7:0]      wr_data_q;
  logic [7:0]      data_o_q;
  logic            drive_q;

  chip_sel_t       sel;
  logic            rise;
  logic            fall_ok;
  logic            wr_go;
  logic            rd_done;
  logic [HW-1:0]   hcnt_nx;
  logic [7:0]      rd_byte;
  logic [7:0]      bus_byte;
  logic [1:0]      load;
  logic [7:0]      load_data;
  logic [7:0]      val [2];

  always_comb begin
    sel      = decode_sel(bus.cs_n);
    rise     = bus.phi2 && !phi2_q;
    hcnt_nx  = (hcnt == H_MAX) ? hcnt : hcnt + 1'b1;
    fall_ok  = (state == HIGH || state == HOLD)
            && !bus.phi2 && (hcnt >= H_MAX);
    wr_go    = fall_ok && !bus.r_w_n && (sel != NONE);
    rd_done  = (state == READ) && (lcnt == L_MAX);
    rd_byte  = (rsel == CHIP1) ? bus.rd_data[15:8]
                               : bus.rd_data[7:0];
    bus_byte = (rsel == CHIP1) ? val[1] : val[0];
    load      = '0;
    load_data = bus.data_i;
    if (wr_go) begin
      load = chip_oh(sel);
    end else if (rd_done && is_readable(rd_addr_q)) begin
      load      = chip_oh(rsel);
      load_data = rd_byte;
    end
  end

  sid_bus_decay #(.DECAY_CYCLES(DECAY_CYCLES)) u_decay0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load[0]),
    .load_data (load_data),
    .tick      (fall_ok),
    .value     (val[0])
  );

  sid_bus_decay #(.DECAY_CYCLES(DECAY_CYCLES)) u_decay1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load[1]),
    .load_data (load_data),
    .tick      (fall_ok),
    .value     (val[1])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      phi2_q    <= 1'b0;
      hcnt      <= '0;
      lcnt      <= '0;
      rsel      <= NONE;
      we_q      <= '0;
      rd_req_q  <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      data_o_q  <= '0;
      drive_q   <= 1'b0;
    end else begin
      phi2_q   <= bus.phi2;
      we_q     <= '0;
      rd_req_q <= '0;
      unique case (state)
        SYNC: begin
          if (!bus.phi2) state <= LOW;
        end
        LOW: begin
          if (rise) begin
            hcnt <= '0;
            if (bus.r_w_n && sel != NONE) begin
              state     <= READ;
              rsel      <= sel;
              rd_addr_q <= bus.addr;
              rd_req_q  <= chip_oh(sel);
              lcnt      <= '0;
            end else begin
              state <= HIGH;
            end
          end
        end
        READ: begin
          hcnt <= hcnt_nx;
          if (rd_done) begin
            data_o_q <= is_readable(rd_addr_q) ? rd_byte
                                               : bus_byte;
            drive_q  <= 1'b1;
            state    <= HOLD;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        HIGH, HOLD: begin
          if (bus.phi2) begin
            hcnt <= hcnt_nx;
          end else begin
            // short high phase is a glitch: drop it silently
            drive_q <= 1'b0;
            state   <= LOW;
            if (wr_go) begin
              we_q      <= chip_oh(sel);
              wr_addr_q <= bus.addr;
              wr_data_q <= bus.data_i;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  assign bus.we      = we_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.data_o  = data_o_q;
  assign bus.drive   = drive_q;
endmodule

// File: tb/tb_sid_bus_ctrl.sv
// Scoreboard bench for sid_bus_ctrl: directed bus cycles push
// expected strobes/reads; a negedge monitor pops and compares.
module tb_sid_bus_ctrl;
  // short decay so the fade-out fits in a few thousand clocks
  localparam int DECAY = 200;
  localparam int MINH  = 4;
  localparam int RDL   = 1;

  typedef enum {K_WR, K_RQ, K_RD} kind_t;
  typedef struct {
    kind_t      k;
    logic [1:0] oh;
    logic [4:0] a;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_rst = 1'b0;
  logic chk_end = 1'b0;
  logic drv_q;
  logic [3:0]  req_sh;
  logic [15:0] core_val = 16'h0000;
  exp_t q[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sid_bus_ctrl_if bus ();

  sid_bus_ctrl #(
    .DECAY_CYCLES (DECAY),
    .MIN_HIGH     (MINH),
    .RD_LAT       (RDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // core model: data valid only RD_LAT clk after rd_req
  always @(posedge clk or posedge rst) begin
    if (rst) req_sh <= '0;
    else     req_sh <= {req_sh[2:0], |bus.rd_req};
  end
  assign bus.rd_data = req_sh[RDL-1] ? core_val : 16'hA5A5;

  task automatic pop_check(
    input kind_t      k,
    input logic [1:0] oh,
    input logic [4:0] a,
    input logic [7:0] d
  );
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      $display("FAIL %s unexpected: got oh=%b a=%h d=%h",
               k.name(), oh, a, d);
      return;
    end
    e = q.pop_front();
    if (e.k == k && e.oh == oh && e.a == a && e.d == d)
      passes++;
    else
      $display("FAIL %s: got oh=%b a=%h d=%h, want %s oh=%b a=%h d=%h",
               k.name(), oh, a, d, e.k.name(), e.oh, e.a, e.d);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (chk_rst) begin
        checks++;
        if (bus.we == 0 && bus.rd_req == 0 && bus.wr_addr == 0 &&
            bus.wr_data == 0 && bus.rd_addr == 0 &&
            bus.data_o == 0 && bus.drive == 0)
          passes++;
        else
          $display("FAIL reset_outputs: we=%b rd_req=%b wa=%h wd=%h ra=%h do=%h drv=%b, want all 0",
                   bus.we, bus.rd_req, bus.wr_addr, bus.wr_data,
                   bus.rd_addr, bus.data_o, bus.drive);
      end
    end else begin
      if (|bus.rd_req)
        pop_check(K_RQ, bus.rd_req, bus.rd_addr, 8'h00);
      if (bus.drive && !drv_q)
        pop_check(K_RD, {1'b0, bus.phi2}, 5'h00, bus.data_o);
      if (|bus.we)
        pop_check(K_WR, bus.we, bus.wr_addr, bus.wr_data);
    end
    if (chk_end) begin
      checks++;
      if (q.size() == 0) passes++;
      else $display("FAIL queue_drain: %0d events left, want 0",
                    q.size());
    end
    drv_q <= bus.drive && !rst;
  end

  task automatic cyc(
    input logic       rw,
    input logic [1:0] cs,
    input logic [4:0] a,
    input logic [7:0] d,
    input int         hi,
    input int         lo
  );
    #1;
    bus.r_w_n  = rw;
    bus.cs_n   = cs;
    bus.addr   = a;
    bus.data_i = d;
    @(posedge clk);
    #1 bus.phi2 = 1'b1;
    repeat (hi) @(posedge clk);
    #1 bus.phi2 = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic wr(
    input logic [1:0] cs,
    input logic [1:0] oh,
    input logic [4:0] a,
    input logic [7:0] d
  );
    q.push_back('{K_WR, oh, a, d});
    cyc(1'b0, cs, a, d, 6, 4);
  endtask

  task automatic rd(
    input logic [1:0] cs,
    input logic [1:0] oh,
    input logic [4:0] a,
    input logic [7:0] d
  );
    q.push_back('{K_RQ, oh, a, 8'h00});
    q.push_back('{K_RD, 2'b01, 5'h00, d});
    cyc(1'b1, cs, a, 8'h00, 6, 4);
  endtask

  task automatic idle();
    cyc(1'b1, 2'b11, 5'h00, 8'h00, 5, 2);
  endtask

  initial begin
    bus.phi2   = 1'b0;
    bus.r_w_n  = 1'b1;
    bus.cs_n   = 2'b11;
    bus.addr   = '0;
    bus.data_i = '0;
    repeat (2) @(posedge clk);
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // chip 0 write, long high phase
    q.push_back('{K_WR, 2'b01, 5'h04, 8'h41});
    cyc(1'b0, 2'b10, 5'h04, 8'h41, 10, 4);

    // readable register loads the bus latch
    core_val = 16'h00C3;
    rd(2'b10, 2'b01, 5'h1B, 8'hC3);
    rd(2'b10, 2'b01, 5'h00, 8'hC3);

    // chip 1 decay: 200 valid falls after the write clear it
    wr(2'b01, 2'b10, 5'h00, 8'h5A);
    repeat (100) idle();
    rd(2'b01, 2'b10, 5'h00, 8'h5A);
    repeat (98) idle();
    // glitch: no strobe, no TTL tick (TTL still 1 here)
    cyc(1'b0, 2'b01, 5'h00, 8'hEE, 2, 4);
    rd(2'b01, 2'b10, 5'h00, 8'h5A);
    rd(2'b01, 2'b10, 5'h00, 8'h00);

    // both selects: chip 0 only, chip 1 latch untouched
    wr(2'b00, 2'b01, 5'h02, 8'h11);
    rd(2'b01, 2'b10, 5'h00, 8'h00);
    rd(2'b10, 2'b01, 5'h00, 8'h11);

    wr(2'b01, 2'b10, 5'h05, 8'h33);
    rd(2'b01, 2'b10, 5'h00, 8'h33);

    // reset while phi2 high during a write
    #1;
    bus.r_w_n  = 1'b0;
    bus.cs_n   = 2'b10;
    bus.addr   = 5'h07;
    bus.data_i = 8'h99;
    @(posedge clk);
    #1 bus.phi2 = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.phi2 = 1'b0;
    repeat (4) @(posedge clk);
    wr(2'b10, 2'b01, 5'h08, 8'h22);

    repeat (5) @(posedge clk);
    chk_end = 1'b1;
    @(negedge clk);
    #1 chk_end = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sid_bus_ctrl.md
Name: sid_bus_ctrl

Overview:
- Sequences CPU bus cycles captured by the SID pad interface into register accesses for two SID cores (chip 0 on /CS, chip 1 on /IO1).
- Tracks the synchronized phi2 phases and issues single-cycle write strobes at the phi2 falling edge.
- Schedules read requests after the phi2 rising edge and returns read data for the pad output register.
- Emulates the decaying data-bus latch, so reads of write-only registers return the last value written to that chip, fading to 0.

Parameters:
- DECAY_CYCLES, 8192, phi2 cycles after the last bus load before the bus value clears to 0.
- MIN_HIGH, 4, minimum clk cycles phi2 must be high for the following falling edge to count as valid.
- RD_LAT, 1, clk cycles from rd_req to valid rd_data from the cores (range 1..3).

Ports:
- clk  in  1  FPGA system clock
- rst  in  1  asynchronous, active-high reset
- phi2  in  1  phi2 already registered into the clk domain
- r_w_n  in  1  latched R/W (1 = read)
- cs_n  in  2  latched active-low selects: [0] = /CS (chip 0), [1] = /IO1 (chip 1)
- addr  in  5  latched register address
- data_i  in  8  latched write data
- we  out  2  one-hot write strobe, one clk wide
- wr_addr  out  5  write address, valid while we != 0
- wr_data  out  8  write data, valid while we != 0
- rd_req  out  2  one-hot read request, one clk wide
- rd_addr  out  5  read address, valid with rd_req
- rd_data  in  16  {chip1, chip0} readable-register data, valid RD_LAT clk after rd_req
- data_o  out  8  read data to the pad output register
- drive  out  1  read data is valid; the pad logic gates the pin OE with this

Behaviour:
- Reset values: all outputs 0; state SYNC; both bus values 0; both TTL counters 0; high counter 0.
- Selection: sel = chip 0 if cs_n[0] = 0; otherwise chip 1 if cs_n[1] = 0; otherwise none. Chip 0 has priority when both selects are asserted; chip 1 is then ignored completely (no write, no bus-value update).
- FSM states: SYNC, LOW, HIGH, READ, HOLD.
- SYNC: waits for phi2 = 0, then goes to LOW. Entered from reset, so a cycle already in progress when reset releases is discarded.
- LOW: on phi2 rising (phi2 = 1, previous 0), clear the high counter; go to READ if r_w_n = 1 and sel != none, else go to HIGH.
- READ: pulse rd_req[sel] with rd_addr = addr. After RD_LAT clk, load data_o and set drive = 1, then go to HOLD.
- Read data mux: addr 0x19..0x1C returns rd_data[sel] and also loads that chip's bus value and TTL. Any other addr returns that chip's bus value.
- HIGH / HOLD: the high counter saturates at MIN_HIGH. On phi2 = 0:
  - If counter >= MIN_HIGH, the falling edge is valid.
  - If counter < MIN_HIGH, it is a glitch: ignore it, clear drive, go to LOW without a write or TTL tick.
- Valid falling edge, same clk: clear drive (data_o keeps its value); go to LOW. If r_w_n = 0 and sel != none, pulse we[sel] with wr_addr = addr and wr_data = data_i, and load the bus value with data_i and the TTL with DECAY_CYCLES.
- TTL: each valid falling edge decrements every nonzero TTL. When a TTL reaches 0, that chip's bus value becomes 0 in the same clk. A load on the same edge takes precedence over the decrement.
- Write-only effect: a write performs no read, so rd_req stays 0.
- Widths: TTL is $clog2(DECAY_CYCLES+1) bits; the high counter is $clog2(MIN_HIGH+1) bits.
- Asynchronous reset mid-cycle aborts any pending strobe or read immediately; no partial strobe may appear after reset.

Decomposition:
- Package sid:
  - bus_ctrl_state_t enum (SYNC, LOW, HIGH, READ, HOLD)
  - register address constants REG_POTX = 5'h19, REG_POTY, REG_OSC3, REG_ENV3 = 5'h1C
  - chip_sel_t (NONE, CHIP0, CHIP1)
- Sub-module sid_bus_decay, instantiated per chip: holds the bus value and TTL counter; inputs load, load_data, tick; output value.

Test Plan:
- Write chip 0: cs_n = 2'b10, r_w_n = 0, addr = 0x04, data = 0x41, phi2 high 10 clk -> exactly one we = 2'b01 on the falling-edge clk with wr_addr = 0x04 and wr_data = 0x41; rd_req stays 0.
- Read-back decay: write 0x5A to chip 1 (addr 0x00), then read addr 0x00 after 100 phi2 cycles -> data_o = 0x5A with drive = 1 while phi2 is high. Read after DECAY_CYCLES + 1 cycles -> data_o = 0x00.
- Readable register: read chip 0 addr 0x1B with rd_data[7:0] = 0xC3 -> rd_req = 2'b01, data_o = 0xC3 RD_LAT + 1 clk after the rise. A following read of addr 0x00 returns 0xC3.
- Both selects: cs_n = 2'b00, write 0x11 -> we = 2'b01 only; chip 1 bus value remains 0.
- Glitch: phi2 high for 2 clk then low with r_w_n = 0 -> no we and no TTL decrement. The next normal cycle writes normally.
- Reset mid-cycle: assert rst while phi2 is high during a write, release it before the fall -> no we for that cycle; the next full cycle writes normally.
